pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_BITS, default 3: width of register-index fields.
REQ-002 Parameter FLUSH_CYCLES, default 2: total cycles IF_ID/ID_EX are squashed after a taken branch; legal range 1..7.
REQ-003 clk  input  1  single pipeline clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 id_src_a, id_src_b  input  REG_BITS each  source register indices of the instruction in IF_ID.
REQ-006 id_use_a, id_use_b  input  1 each  the IF_ID instruction actually reads src_a / src_b.
REQ-007 ex_dst  input  REG_BITS  destination index of the instruction in ID_EX.
REQ-008 ex_mem_read  input  1  the ID_EX instruction is a load.
REQ-009 ex_reg_write  input  1  the ID_EX instruction writes ex_dst.
REQ-010 branch_taken  input  1  the EX stage resolved a taken branch/jump this cycle.
REQ-011 mem_busy  input  1  data memory not ready; the whole pipeline freezes.
REQ-012 pc_write  output  1  PC may load its next value.
REQ-013 if_id_write  output  1  IF_ID may capture.
REQ-014 if_id_flush  output  1  IF_ID loads a NOP.
REQ-015 id_ex_bubble  output  1  ID_EX loads zeroed control bits (no mem_write, no reg_write, no flag writes).
REQ-016 pipe_freeze  output  1  all pipeline registers hold.
REQ-017 state  output  2  FSM state: 0 RUN, 1 FLUSH, 2 FREEZE.
REQ-018 stall_cnt  output  8  saturating count of lost cycles (load-use, flush, freeze).

Function
REQ-019 load_use = ex_mem_read & ex_reg_write & (ex_dst != 0) & ((id_use_a & id_src_a == ex_dst) | (id_use_b & id_src_b == ex_dst)); register 0 never causes a hazard.
REQ-020 Priority per cycle: reset > mem_busy > branch_taken / FLUSH > load_use > normal.
REQ-021 RUN, no event: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_freeze=0.
REQ-022 RUN, load_use only: same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; state stays RUN; exactly one stall cycle per load (the load leaves ID_EX next edge).
REQ-023 RUN, branch_taken: same cycle pc_write=1, if_id_flush=1, id_ex_bubble=1; flush counter loads FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-024 FLUSH: if_id_flush=1, id_ex_bubble=1, pc_write=1; counter decrements each cycle; returns to RUN in the cycle after it reaches 1; load_use ignored in FLUSH.
REQ-025 branch_taken while in FLUSH restarts the counter at FLUSH_CYCLES-1.
REQ-026 mem_busy=1 in any state: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, pipe_freeze=1; state goes to FREEZE; prior state and flush counter are preserved and resumed when mem_busy drops; branch_taken/load_use ignored while frozen.
REQ-027 FREEZE with mem_busy=0: outputs evaluated as in the saved state in that same cycle; next state is the saved state.
REQ-028 stall_cnt increments by 1 in every cycle where pc_write=0 or id_ex_bubble=1; holds at 255.
REQ-029 Outputs are combinational from registered state and current inputs; no output depends on a combinational loop through itself.

Reset
REQ-030 On reset: state=RUN, flush counter=0, saved state=RUN, stall_cnt=0; during the reset cycle pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0.
REQ-031 Reset asserted mid-FLUSH or mid-FREEZE aborts it; first cycle after reset deasserts behaves as RUN.

Verification
REQ-032 ex_mem_read=1, ex_reg_write=1, ex_dst=3, id_src_a=3, id_use_a=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle only; stall_cnt 0->1.
REQ-033 Same as REQ-032 but ex_dst=0 or id_use_a=0 -> no stall, pc_write=1.
REQ-034 branch_taken pulse, FLUSH_CYCLES=2 -> if_id_flush=1 for exactly 2 cycles, state 0->1->0, stall_cnt +2.
REQ-035 branch_taken in cycle 0, mem_busy in cycles 1-3 -> pipe_freeze=1 cycles 1-3, flush completes in cycle 4, RUN in cycle 5.
REQ-036 load_use and branch_taken together -> flush wins: pc_write=1, if_id_flush=1.
REQ-037 Hold load_use 300 cycles -> stall_cnt saturates at 255; reset mid-FLUSH -> state=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline datapath and the hazard controller.
// Slave is the controller; master drives instruction fields and consumes stall controls.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_BITS = 3
);
    logic [REG_BITS-1:0] id_src_a;
    logic [REG_BITS-1:0] id_src_b;
    logic                id_use_a;
    logic                id_use_b;
    logic [REG_BITS-1:0] ex_dst;
    logic                ex_mem_read;
    logic                ex_reg_write;
    logic                branch_taken;
    logic                mem_busy;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic                pipe_freeze;
    logic [1:0]          state;
    logic [7:0]          stall_cnt;

    modport slave (
        input  id_src_a, id_src_b, id_use_a, id_use_b, ex_dst, ex_mem_read,
               ex_reg_write, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
               state, stall_cnt
    );

    modport master (
        output id_src_a, id_src_b, id_use_a, id_use_b, ex_dst, ex_mem_read,
               ex_reg_write, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
               state, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch flushes,
// memory-busy freezes, and a saturating lost-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int REG_BITS     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [7:0] stall_q, stall_d;

    state_t eff_state;
    logic   load_use;
    logic   pc_w, ifid_w, ifid_fl, bubble, freeze;

    always_comb begin
        load_use = hz.ex_mem_read && hz.ex_reg_write && (hz.ex_dst != '0) &&
                   ((hz.id_use_a && (hz.id_src_a == hz.ex_dst)) ||
                    (hz.id_use_b && (hz.id_src_b == hz.ex_dst)));
        // Leaving FREEZE behaves exactly like the state that was interrupted.
        eff_state = (state_q == FREEZE) ? saved_q : state_q;

        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_fl = 1'b0;
        bubble  = 1'b0;
        freeze  = 1'b0;
        state_d = eff_state;
        saved_d = saved_q;
        cnt_d   = cnt_q;

        if (reset) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            ifid_fl = 1'b1;
            bubble  = 1'b1;
            state_d = RUN;
            saved_d = RUN;
            cnt_d   = '0;
        end else if (hz.mem_busy) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            freeze  = 1'b1;
            state_d = FREEZE;
            saved_d = eff_state;
        end else if (hz.branch_taken) begin
            ifid_fl = 1'b1;
            bubble  = 1'b1;
            cnt_d   = FLUSH_RELOAD;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (eff_state == FLUSH) begin
            ifid_fl = 1'b1;
            bubble  = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q <= 3'd1) ? RUN : FLUSH;
        end else if (load_use) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
        end

        stall_d = stall_q;
        if ((!pc_w || bubble) && (stall_q != 8'hFF))
            stall_d = stall_q + 8'd1;

        hz.pc_write     = pc_w;
        hz.if_id_write  = ifid_w;
        hz.if_id_flush  = ifid_fl;
        hz.id_ex_bubble = bubble;
        hz.pipe_freeze  = freeze;
        hz.state        = state_q;
        hz.stall_cnt    = stall_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step queues the expected outputs
// and compares them mid-cycle against the DUT.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_BITS(3)) hz ();

    pipeline_hazard_ctrl #(.REG_BITS(3), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // flags = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
    typedef struct {
        logic [4:0] flags;
        logic [1:0] st;
        logic [7:0] stall;
        int         step;
    } exp_t;

    localparam logic [4:0] F_NORM  = 5'b11000;
    localparam logic [4:0] F_LOAD  = 5'b00010;
    localparam logic [4:0] F_FLUSH = 5'b11110;
    localparam logic [4:0] F_FRZ   = 5'b00001;
    localparam logic [4:0] F_RST   = 5'b00110;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    task automatic drive(input logic rst, input logic mr, input logic rw,
                         input logic [2:0] dst, input logic [2:0] sa, input logic ua,
                         input logic [2:0] sb_i, input logic ub,
                         input logic br, input logic busy);
        reset           = rst;
        hz.ex_mem_read  = mr;
        hz.ex_reg_write = rw;
        hz.ex_dst       = dst;
        hz.id_src_a     = sa;
        hz.id_use_a     = ua;
        hz.id_src_b     = sb_i;
        hz.id_use_b     = ub;
        hz.branch_taken = br;
        hz.mem_busy     = busy;
    endtask

    task automatic expect_cycle(input logic [4:0] flags, input logic [1:0] st,
                                input logic [7:0] stall);
        exp_t e;
        logic [4:0] obs;
        e.flags = flags; e.st = st; e.stall = stall; e.step = step_no;
        sb.push_back(e);
        step_no++;
        @(negedge clk);
        e = sb.pop_front();
        obs = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_bubble, hz.pipe_freeze};
        n_cmp++;
        assert (obs === e.flags) else begin
            n_fail++;
            $error("FAIL flags step%0d observed=%b expected=%b", e.step, obs, e.flags);
        end
        n_cmp++;
        assert (hz.state === e.st) else begin
            n_fail++;
            $error("FAIL state step%0d observed=%0d expected=%0d", e.step, hz.state, e.st);
        end
        n_cmp++;
        assert (hz.stall_cnt === e.stall) else begin
            n_fail++;
            $error("FAIL stall_cnt step%0d observed=%0d expected=%0d", e.step, hz.stall_cnt, e.stall);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        expect_cycle(F_RST, 0, 0);
        // Idle and load-use variants
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 0);
        drive(0, 1, 1, 3, 3, 1, 0, 0, 0, 0); expect_cycle(F_LOAD, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 1);
        drive(0, 1, 1, 3, 3, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 1);
        drive(0, 1, 1, 5, 1, 1, 5, 1, 0, 0); expect_cycle(F_LOAD, 0, 1);
        drive(0, 1, 0, 5, 5, 1, 5, 1, 0, 0); expect_cycle(F_NORM, 0, 2);
        // Branch pulse: two flush cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cycle(F_FLUSH, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_FLUSH, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 4);
        // Branch with load-use: flush wins, load-use ignored in FLUSH
        drive(0, 1, 1, 3, 3, 1, 0, 0, 1, 0); expect_cycle(F_FLUSH, 0, 4);
        drive(0, 1, 1, 3, 3, 1, 0, 0, 0, 0); expect_cycle(F_FLUSH, 1, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 6);
        // Branch during FLUSH restarts the counter
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cycle(F_FLUSH, 0, 6);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cycle(F_FLUSH, 1, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_FLUSH, 1, 8);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 9);
        // Branch then freeze for three cycles; flush resumes afterwards
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cycle(F_FLUSH, 0, 9);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_cycle(F_FRZ, 1, 10);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_cycle(F_FRZ, 2, 11);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_cycle(F_FRZ, 2, 12);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_FLUSH, 2, 13);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 14);
        // Branch and load-use are both ignored while frozen
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); expect_cycle(F_FRZ, 0, 14);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 2, 15);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 15);
        drive(0, 1, 1, 2, 2, 1, 0, 0, 0, 1); expect_cycle(F_FRZ, 0, 15);
        drive(0, 1, 1, 2, 2, 1, 0, 0, 0, 0); expect_cycle(F_LOAD, 2, 16);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 17);
        // Held load-use saturates the stall counter
        drive(0, 1, 1, 7, 0, 0, 7, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            expect_cycle(F_LOAD, 0, (17 + i > 255) ? 8'd255 : 8'(17 + i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 255);
        // Reset mid-FLUSH
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cycle(F_FLUSH, 0, 255);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_RST, 1, 255);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 0);
        // Reset mid-FREEZE
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_cycle(F_FRZ, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_cycle(F_RST, 2, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(F_NORM, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
